// File: rtl/jb_dl_sat_err_collect.sv
// Sticky I/Q saturation status collector for one DL DFE stage, 4 antennas per instance.
// Optional sat_irq / irq_mask ports are added when JB_SAT_ERR_IRQ_EN is defined.
module jb_dl_sat_err_collect #(
  parameter int NUM_ANT = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               sat_vld,
  input  logic [NUM_ANT-1:0] sat_i,
  input  logic [NUM_ANT-1:0] sat_q,
  input  logic               clr_req,
`ifdef JB_SAT_ERR_IRQ_EN
  input  logic               irq_mask,
  output logic               sat_irq,
`endif
  output logic               clr_ack,
  output logic [31:0]        sat_err_status,
  output logic               sat_active
);

  // The packed status word has room for exactly 4 antennas and a 16-bit counter.
  if (NUM_ANT != 4) begin : g_num_ant_check
    $error("jb_dl_sat_err_collect: NUM_ANT must be 4");
  end
  if (CNT_W < 4 || CNT_W > 16) begin : g_cnt_w_check
    $error("jb_dl_sat_err_collect: CNT_W must be in 4..16");
  end

  typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_reg, state_next;
  logic [NUM_ANT-1:0] sticky_i_reg, sticky_i_next;
  logic [NUM_ANT-1:0] sticky_q_reg, sticky_q_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               flag_reg, flag_next;
  logic               active_reg, active_next;
  logic               clr_ack_reg;

  logic               qual;
  logic               clear_now;
  logic [1:0]         ant_hits [NUM_ANT];
  logic [3:0]         ev_cnt;
  logic [CNT_W:0]     cnt_sum;
  logic               cnt_clip;

  assign qual      = enable & sat_vld;
  assign clear_now = clr_req & (state_reg != CLEAR);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ANT; gi++) begin : g_ant
      assign ant_hits[gi] = {1'b0, sat_i[gi]} + {1'b0, sat_q[gi]};
    end
  endgenerate

  always_comb begin
    ev_cnt = '0;
    for (int k = 0; k < NUM_ANT; k++) begin
      ev_cnt = ev_cnt + {2'b00, ant_hits[k]};
    end
  end

  assign cnt_sum  = {1'b0, cnt_reg} + {{(CNT_W-3){1'b0}}, ev_cnt};
  assign cnt_clip = (cnt_sum >= {1'b0, CNT_MAX});

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (clr_req) state_next = CLEAR;
               else if (enable) state_next = RUN;
      RUN:     if (clr_req) state_next = CLEAR;
               else if (!enable) state_next = IDLE;
      CLEAR:   state_next = enable ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A clear wins over a coincident event; an event in the CLEAR cycle starts fresh.
  always_comb begin
    sticky_i_next = sticky_i_reg;
    sticky_q_next = sticky_q_reg;
    cnt_next      = cnt_reg;
    flag_next     = flag_reg;
    active_next   = 1'b0;
    if (clear_now) begin
      sticky_i_next = '0;
      sticky_q_next = '0;
      cnt_next      = '0;
      flag_next     = 1'b0;
    end else if (qual) begin
      sticky_i_next = sticky_i_reg | sat_i;
      sticky_q_next = sticky_q_reg | sat_q;
      cnt_next      = cnt_clip ? CNT_MAX : cnt_sum[CNT_W-1:0];
      flag_next     = flag_reg | cnt_clip;
      active_next   = |(sat_i | sat_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      sticky_i_reg <= '0;
      sticky_q_reg <= '0;
      cnt_reg      <= '0;
      flag_reg     <= 1'b0;
      active_reg   <= 1'b0;
      clr_ack_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sticky_i_reg <= sticky_i_next;
      sticky_q_reg <= sticky_q_next;
      cnt_reg      <= cnt_next;
      flag_reg     <= flag_next;
      active_reg   <= active_next;
      clr_ack_reg  <= clear_now;
    end
  end

`ifdef JB_SAT_ERR_IRQ_EN
  // One interrupt per clear epoch; a masked first rise still disarms it.
  logic armed_reg, armed_next;
  logic irq_reg, irq_next;
  logic rise;

  assign rise = qual & ~clear_now &
                (|((sat_i & ~sticky_i_reg) | (sat_q & ~sticky_q_reg)));

  always_comb begin
    armed_next = armed_reg;
    irq_next   = 1'b0;
    if (clear_now) begin
      armed_next = 1'b1;
    end else if (rise && armed_reg) begin
      armed_next = 1'b0;
      irq_next   = ~irq_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_reg <= 1'b1;
      irq_reg   <= 1'b0;
    end else begin
      armed_reg <= armed_next;
      irq_reg   <= irq_next;
    end
  end

  assign sat_irq = irq_reg;
`endif

  assign clr_ack        = clr_ack_reg;
  assign sat_active     = active_reg;
  assign sat_err_status = {6'b0, active_reg, flag_reg, 16'(cnt_reg), sticky_q_reg, sticky_i_reg};

endmodule

// File: tb/tb_jb_dl_sat_err_collect.sv
// Scoreboard bench for jb_dl_sat_err_collect: a behavioural model pushes expected
// outputs per driven cycle; they are popped and compared one cycle later.
module tb_jb_dl_sat_err_collect;

  logic        clk = 1'b0;
  logic        rst, enable, sat_vld, clr_req;
  logic [3:0]  sat_i, sat_q;
  logic        irq_mask;
  logic        sat_irq_w;
  logic        clr_ack;
  logic [31:0] sat_err_status;
  logic        sat_active;

  always #5 clk = ~clk;

  jb_dl_sat_err_collect #(.NUM_ANT(4), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .sat_vld        (sat_vld),
    .sat_i          (sat_i),
    .sat_q          (sat_q),
    .clr_req        (clr_req),
`ifdef JB_SAT_ERR_IRQ_EN
    .irq_mask       (irq_mask),
    .sat_irq        (sat_irq_w),
`endif
    .clr_ack        (clr_ack),
    .sat_err_status (sat_err_status),
    .sat_active     (sat_active)
  );

`ifndef JB_SAT_ERR_IRQ_EN
  assign sat_irq_w = 1'b0;
`endif

  typedef struct {
    logic [31:0] status;
    logic        ack;
    logic        active;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // model state
  int   m_state = 0;        // 0 idle, 1 run, 2 clear
  logic [3:0] m_si = '0, m_sq = '0;
  int   m_cnt = 0;
  logic m_flag = 1'b0, m_act = 1'b0, m_armed = 1'b1;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int popc(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  task automatic step(input string tag, input logic r, input logic en, input logic vld,
                      input logic [3:0] i, input logic [3:0] q, input logic clr,
                      input bit verbose);
    exp_t e;
    exp_t got;
    bit   clr_eff;
    bit   rise;
    int   sum;
    rst = r; enable = en; sat_vld = vld; sat_i = i; sat_q = q; clr_req = clr;
    e.irq = 1'b0;
    if (r) begin
      m_state = 0; m_si = '0; m_sq = '0; m_cnt = 0; m_flag = 0; m_act = 0; m_armed = 1;
      e.ack = 1'b0;
    end else begin
      clr_eff = clr && (m_state != 2);
      e.ack = clr_eff;
      if (clr_eff) begin
        m_si = '0; m_sq = '0; m_cnt = 0; m_flag = 0; m_act = 0; m_armed = 1;
      end else if (en && vld) begin
        rise = ((i & ~m_si) != 0) || ((q & ~m_sq) != 0);
        if (rise && m_armed) begin
          m_armed = 0;
          e.irq = !irq_mask;
        end
        m_si = m_si | i;
        m_sq = m_sq | q;
        sum = m_cnt + popc(i) + popc(q);
        if (sum >= 65535) begin
          m_cnt = 65535;
          m_flag = 1;
        end else begin
          m_cnt = sum;
        end
        m_act = (i | q) != 0;
      end else begin
        m_act = 0;
      end
      if (m_state == 2) m_state = en ? 1 : 0;
      else if (clr) m_state = 2;
      else m_state = en ? 1 : 0;
    end
    e.active = m_act;
    e.status = {6'b0, m_act, m_flag, m_cnt[15:0], m_sq, m_si};
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check_value({tag, ".status"}, sat_err_status, got.status);
    check_value({tag, ".ack"}, {31'b0, clr_ack}, {31'b0, got.ack});
    check_value({tag, ".active"}, {31'b0, sat_active}, {31'b0, got.active});
`ifdef JB_SAT_ERR_IRQ_EN
    check_value({tag, ".irq"}, {31'b0, sat_irq_w}, {31'b0, got.irq});
`endif
    if (verbose)
      $display("txn %-10s rst=%0b en=%0b vld=%0b i=%h q=%h clr=%0b -> status=0x%08h ack=%0b act=%0b",
               tag, r, en, vld, i, q, clr, sat_err_status, clr_ack, sat_active);
  endtask

  initial begin
    irq_mask = 1'b0;
    rst = 1'b1; enable = 0; sat_vld = 0; sat_i = 0; sat_q = 0; clr_req = 0;
    #1;

    // reset state
    step("reset0", 1, 0, 0, 4'h0, 4'h0, 0, 1);
    step("reset1", 1, 0, 0, 4'h0, 4'h0, 0, 1);
    check_value("reset_const", sat_err_status, 32'h0);

    // first event and an idle cycle after it
    step("ev0101", 0, 1, 1, 4'h5, 4'h0, 0, 1);
    check_value("ev0101_const", sat_err_status, 32'h0200_0205);
    step("idle", 0, 1, 0, 4'h0, 4'h0, 0, 1);
    check_value("idle_const", sat_err_status, 32'h0000_0205);

    // build 0x0F33 then clear with a coincident event
    step("clr_a", 0, 1, 0, 4'h0, 4'h0, 1, 1);
    step("clr_a2", 0, 1, 0, 4'h0, 4'h0, 0, 1);
    for (int k = 0; k < 3; k++) step("b33", 0, 1, 1, 4'h3, 4'h3, 0, 1);
    step("b12", 0, 1, 1, 4'h1, 4'h2, 0, 1);
    step("b10", 0, 1, 1, 4'h1, 4'h0, 0, 1);
    step("bidle", 0, 1, 0, 4'h0, 4'h0, 0, 1);
    check_value("f33_const", sat_err_status, 32'h0000_0F33);
    step("clr_ev", 0, 1, 1, 4'hF, 4'hF, 1, 1);
    check_value("clr_ack_const", {31'b0, clr_ack}, 32'h1);
    check_value("clr_zero_const", sat_err_status, 32'h0);
    step("clrcyc_ev", 0, 1, 1, 4'h4, 4'h0, 1, 1);
    check_value("clrcyc_const", sat_err_status, 32'h0200_0104);
    step("post", 0, 1, 0, 4'h0, 4'h0, 0, 1);

    // enable low: inputs ignored, status frozen
    for (int k = 0; k < 10; k++) step("dis", 0, 0, 1, 4'hF, 4'h0, 0, 0);
    check_value("dis_const", sat_err_status, 32'h0000_0104);
    step("reen", 0, 1, 1, 4'h0, 4'h8, 0, 1);
    check_value("reen_const", sat_err_status, 32'h0200_0284);

    // counter saturation
    step("clr_s", 0, 1, 0, 4'h0, 4'h0, 1, 1);
    for (int k = 0; k < 8192; k++) step("satrun", 0, 1, 1, 4'hF, 4'hF, 0, 0);
    check_value("sat_const", sat_err_status, 32'h03FF_FFFF);
    for (int k = 0; k < 4; k++) step("satmore", 0, 1, 1, 4'h2, 4'h0, 0, 1);
    check_value("satmore_const", sat_err_status, 32'h03FF_FFFF);

    // held clr_req: only one ack
    step("clr_h0", 0, 1, 0, 4'h0, 4'h0, 1, 1);
    step("clr_h1", 0, 1, 0, 4'h0, 4'h0, 1, 1);
    check_value("clr_h1_const", {31'b0, clr_ack}, 32'h0);

    // reset the cycle after clr_req
    step("ev", 0, 1, 1, 4'h1, 4'h1, 0, 1);
    step("clr_r", 0, 1, 0, 4'h0, 4'h0, 1, 1);
    step("rst_clr", 1, 1, 0, 4'h0, 4'h0, 0, 1);
    check_value("rst_clr_ack_const", {31'b0, clr_ack}, 32'h0);
    step("after_r", 0, 0, 0, 4'h0, 4'h0, 0, 1);
    step("after_r2", 0, 0, 0, 4'h0, 4'h0, 0, 1);

`ifdef JB_SAT_ERR_IRQ_EN
    step("irq_clr", 0, 1, 0, 4'h0, 4'h0, 1, 1);
    step("irq_q2", 0, 1, 1, 4'h0, 4'h4, 0, 1);
    check_value("irq_first_const", {31'b0, sat_irq_w}, 32'h1);
    step("irq_rep", 0, 1, 1, 4'h0, 4'h4, 0, 1);
    step("irq_new", 0, 1, 1, 4'h1, 4'h0, 0, 1);
    step("irq_clr2", 0, 1, 0, 4'h0, 4'h0, 1, 1);
    step("irq_again", 0, 1, 1, 4'h0, 4'h4, 0, 1);
    step("irq_clr3", 0, 1, 0, 4'h0, 4'h0, 1, 1);
    irq_mask = 1'b1;
    step("irq_masked", 0, 1, 1, 4'h0, 4'h4, 0, 1);
    irq_mask = 1'b0;
    step("irq_unmask", 0, 1, 1, 4'h2, 4'h0, 0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
